// File: rtl/rv32i_pkg.sv
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : Shared RV32I constants, fetch buffer entry type and helpers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

   localparam int               XLEN             = 32;
   localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0]  NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Two-entry {instr,pc} buffer between instruction memory and decode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import rv32i_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   // Storage is cleared on reset so instr/instr_pc read zero while held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= push_entry;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Single-outstanding instruction fetch with redirect and 2-deep buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_outstanding;
   logic            r_drop;

   logic            w_grant;
   logic            w_push;
   logic            w_pop;
   logic [1:0]      w_count;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

   // rst_n gates the request so nothing is offered to memory while held in reset.
   assign imem_req  = rst_n & ~r_outstanding & (w_count < 2'd2) & ~redirect;
   assign imem_addr = word_align(r_pc);
   assign w_grant   = imem_req & imem_gnt;

   // A response is kept only if no redirect has invalidated it.
   assign w_push       = imem_rvalid & r_outstanding & ~r_drop & ~redirect;
   assign w_pop        = instr_valid & instr_ready;
   assign w_push_entry = '{instr: imem_rdata, pc: r_req_pc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         if (redirect) begin
            r_pc <= word_align(redirect_pc);
         end else if (w_grant) begin
            r_pc <= imem_addr + XLEN'(4);
         end

         if (w_grant) begin
            r_outstanding <= 1'b1;
            r_req_pc      <= imem_addr;
         end else if (imem_rvalid) begin
            r_outstanding <= 1'b0;
         end

         // A response landing with the redirect is discarded directly, so no drop.
         if (imem_rvalid) begin
            r_drop <= 1'b0;
         end else if (redirect && r_outstanding) begin
            r_drop <= 1'b1;
         end
      end
   end

   fetch_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (w_push),
      .push_entry (w_push_entry),
      .pop        (w_pop),
      .head       (w_head),
      .count      (w_count)
   );

   assign instr_valid = (w_count != 2'd0);
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int          errors = 0;
   int          checks = 0;
   logic        hold_resp = 1'b0;
   logic        pending = 1'b0;
   logic [31:0] paddr = 32'h0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0013;
   endfunction

   // Memory model: a grant seen in cycle k yields rvalid in cycle k+1 unless held.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) pending = 1'b0;
         else if (imem_req && imem_gnt) begin
            pending = 1'b1;
            paddr   = imem_addr;
         end
         @(posedge clk);
         #2;
         if (!rst_n) begin
            pending     = 1'b0;
            imem_rvalid = 1'b0;
         end else if (pending && !hold_resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pending     = 1'b0;
         end else begin
            imem_rvalid = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves time at posedge+1 of the first cycle after reset release (cycle 0).
   task automatic do_reset(input logic gnt, input logic rdy, input logic hold);
      rst_n     = 1'b0;
      redirect  = 1'b0;
      imem_gnt  = gnt;
      instr_ready = rdy;
      hold_resp = hold;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      imem_gnt = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset imem_req: got %b exp 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid: got %b exp 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset instr: got %h exp 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset instr_pc: got %h exp 0", instr_pc); end
   endtask

   task automatic test_basic();
      logic [6:0]  exp_req;
      logic [6:0]  exp_val;
      logic [31:0] exp_addr [7];
      logic [31:0] exp_pc   [7];
      exp_req  = 7'b1010101;
      exp_val  = 7'b1010100;
      exp_addr = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
      exp_pc   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
      do_reset(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         @(negedge clk);
         checks++; if (imem_req !== exp_req[i]) begin errors++; $display("FAIL basic req c%0d: got %b exp %b", i, imem_req, exp_req[i]); end
         if (exp_req[i]) begin
            checks++; if (imem_addr !== exp_addr[i]) begin errors++; $display("FAIL basic addr c%0d: got %h exp %h", i, imem_addr, exp_addr[i]); end
         end
         checks++; if (instr_valid !== exp_val[i]) begin errors++; $display("FAIL basic valid c%0d: got %b exp %b", i, instr_valid, exp_val[i]); end
         if (exp_val[i]) begin
            checks++; if (instr_pc !== exp_pc[i]) begin errors++; $display("FAIL basic pc c%0d: got %h exp %h", i, instr_pc, exp_pc[i]); end
            checks++; if (instr !== mem_word(exp_pc[i])) begin errors++; $display("FAIL basic instr c%0d: got %h exp %h", i, instr, mem_word(exp_pc[i])); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b1, 1'b0, 1'b0);
      repeat (9) step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp full valid: got %b exp 1", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp full req: got %b exp 0", imem_req); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp held pc: got %h exp 0", instr_pc); end
      checks++; if (instr !== mem_word(32'h0)) begin errors++; $display("FAIL bp held instr: got %h exp %h", instr, mem_word(32'h0)); end
      step();
      instr_ready = 1'b1;
      @(negedge clk);
      checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp first pc: got %h v=%b exp 0 v=1", instr_pc, instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp first req: got %b exp 0", imem_req); end
      step();
      @(negedge clk);
      checks++; if (instr_pc !== 32'h4 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp second pc: got %h v=%b exp 4 v=1", instr_pc, instr_valid); end
      checks++; if (instr !== mem_word(32'h4)) begin errors++; $display("FAIL bp second instr: got %h exp %h", instr, mem_word(32'h4)); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp refetch: got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp drained valid: got %b exp 0", instr_valid); end
      step();
      @(negedge clk);
      checks++; if (instr_pc !== 32'h8 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp third pc: got %h v=%b exp 8 v=1", instr_pc, instr_valid); end
   endtask

   task automatic test_gnt_stall();
      do_reset(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         @(negedge clk);
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall c%0d: got req=%b addr=%h exp req=1 addr=0", i, imem_req, imem_addr); end
      end
      step();
      imem_gnt = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stall grant: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      step();
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall outstanding req: got %b exp 0", imem_req); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL stall deliver: got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall next addr: got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_outstanding();
      do_reset(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL redir first req: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      step();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir cycle req: got %b exp 0", imem_req); end
      step();
      redirect = 1'b0;
      hold_resp = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir wait req: got %b exp 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir wait valid: got %b exp 0", instr_valid); end
      step();
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir new addr: got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir dropped valid: got %b exp 0", instr_valid); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir pre valid: got %b exp 0", instr_valid); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL redir deliver: got v=%b pc=%h exp v=1 pc=100", instr_valid, instr_pc); end
      checks++; if (instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir instr: got %h exp %h", instr, mem_word(32'h100)); end
   endtask

   task automatic test_redirect_rvalid();
      do_reset(1'b1, 1'b1, 1'b0);
      step();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rvredir cycle req: got %b exp 0", imem_req); end
      step();
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rvredir discard valid: got %b exp 0", instr_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rvredir addr: got req=%b addr=%h exp req=1 addr=fffffffc", imem_req, imem_addr); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rvredir wait: got v=%b req=%b exp v=0 req=0", instr_valid, imem_req); end
      step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rvredir deliver: got v=%b pc=%h exp v=1 pc=fffffffc", instr_valid, instr_pc); end
      checks++; if (instr !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL rvredir instr: got %h exp %h", instr, mem_word(32'hFFFF_FFFC)); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rvredir wrap: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      repeat (2) step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rvredir wrap deliver: got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1, 1'b0, 1'b0);
      repeat (5) step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL areset full: got v=%b req=%b exp v=1 req=0", instr_valid, imem_req); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset valid: got %b exp 0", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset req: got %b exp 0", imem_req); end
      checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL areset data: got %h/%h exp 0/0", instr, instr_pc); end
      step();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset restart: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset restart valid: got %b exp 0", instr_valid); end
      repeat (2) step();
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL areset deliver: got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gnt_stall();
      test_redirect_outstanding();
      test_redirect_rvalid();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
